// File: rtl/vga_capture_monitor.sv
// VGA capture monitor: measures hsync/vsync timing, locks after LOCK_FRAMES good frames
// and emits pixel coordinates/colours. Optional per-frame CRC via VGA_MON_CRC_EN.
module vga_capture_monitor #(
    parameter int H_ACTIVE        = 640,
    parameter int H_SYNC_START    = 656,
    parameter int H_TOTAL         = 800,
    parameter int V_ACTIVE        = 480,
    parameter int V_SYNC_START    = 490,
    parameter int V_TOTAL         = 525,
    parameter int LOCK_FRAMES     = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [1:0]  vga_r,
    input  logic [1:0]  vga_g,
    input  logic [1:0]  vga_b,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [1:0]  pix_r,
    output logic [1:0]  pix_g,
    output logic [1:0]  pix_b,
    output logic        frame_done,
    output logic        lost_lock,
    output logic [7:0]  err_count,
    output logic [15:0] frame_crc
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic        INACT   = (SYNC_ACTIVE_LOW != 0);
    localparam logic [9:0]  H_SS    = 10'(H_SYNC_START);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0]  V_SS    = 10'(V_SYNC_START);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
    localparam logic [11:0] H_TOT12 = 12'(H_TOTAL);
    localparam logic [11:0] V_TOT12 = 12'(V_TOTAL);
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

    logic       hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [5:0] rgb_q, rgb2_q;

    // Sync registers reset to the inactive level so reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q      <= INACT;
            vs_q      <= INACT;
            hs_prev_q <= INACT;
            vs_prev_q <= INACT;
            rgb_q     <= '0;
            rgb2_q    <= '0;
        end else begin
            hs_q      <= hsync;
            vs_q      <= vsync;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            rgb_q     <= {vga_r, vga_g, vga_b};
            rgb2_q    <= rgb_q;
        end
    end

    logic h_edge, v_edge;
    assign h_edge = (hs_prev_q == INACT) && (hs_q != INACT);
    assign v_edge = (vs_prev_q == INACT) && (vs_q != INACT);

    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [11:0] len_q, len_d, lines_q, lines_d, lines_meas;
    logic        have_h_q, have_h_d, have_v_q, have_v_d;
    logic        lerr_seen_q, lerr_seen_d;
    logic [7:0]  err_q, err_d;
    logic        h_wrap, line_err, frame_err, frame_bad, err_evt;
    state_t      state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic        lost_lock_q, lost_lock_d, frame_done_q, frame_done_d;

    assign h_wrap     = !h_edge && (h_cnt_q == H_LAST);
    assign lines_meas = lines_q + 12'(h_edge);
    assign line_err   = h_edge && have_h_q && ((len_q + 12'd1) != H_TOT12);
    assign frame_err  = v_edge && have_v_q && (lines_meas != V_TOT12);
    assign frame_bad  = line_err || frame_err || lerr_seen_q;
    assign err_evt    = (line_err || frame_err) && (state_q != SEARCH);

    always_comb begin
        h_cnt_d = h_edge ? H_SS : (h_wrap ? 10'd0 : h_cnt_q + 10'd1);
        v_cnt_d = v_cnt_q;
        if (v_edge)
            v_cnt_d = V_SS;
        else if (h_wrap)
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        // Measurement counters saturate so a missing sync cannot alias to a legal length.
        len_d       = h_edge ? 12'd0 : ((len_q == 12'hFFF) ? len_q : len_q + 12'd1);
        lines_d     = v_edge ? 12'd0 : ((lines_meas < lines_q) ? lines_q : lines_meas);
        have_h_d    = have_h_q || h_edge;
        have_v_d    = have_v_q || v_edge;
        lerr_seen_d = v_edge ? 1'b0 : (lerr_seen_q || line_err);
        err_d       = (err_evt && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            len_q       <= '0;
            lines_q     <= '0;
            have_h_q    <= 1'b0;
            have_v_q    <= 1'b0;
            lerr_seen_q <= 1'b0;
            err_q       <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            len_q       <= len_d;
            lines_q     <= lines_d;
            have_h_q    <= have_h_d;
            have_v_q    <= have_v_d;
            lerr_seen_q <= lerr_seen_d;
            err_q       <= err_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEARCH;
            good_q       <= '0;
            lost_lock_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            lost_lock_q  <= lost_lock_d;
            frame_done_q <= frame_done_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                if (v_edge) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            MEASURE: begin
                if (v_edge) begin
                    if (frame_bad) begin
                        good_d = '0;
                    end else if (good_q + 8'd1 >= LOCK_N) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 8'd1;
                    end
                end
            end
            LOCKED: begin
                if (line_err || frame_err) begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        locked       = (state_q == LOCKED);
        lost_lock_d  = locked && (line_err || frame_err);
        frame_done_d = locked && v_edge && !(line_err || frame_err);
    end

    assign pix_valid  = locked && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign pix_x      = h_cnt_q;
    assign pix_y      = v_cnt_q;
    assign pix_r      = pix_valid ? rgb2_q[5:4] : 2'd0;
    assign pix_g      = pix_valid ? rgb2_q[3:2] : 2'd0;
    assign pix_b      = pix_valid ? rgb2_q[1:0] : 2'd0;
    assign frame_done = frame_done_q;
    assign lost_lock  = lost_lock_q;
    assign err_count  = err_q;

`ifdef VGA_MON_CRC_EN
    logic [15:0] crc_q, crc_acc, frame_crc_q;
    logic [5:0]  sym;

    // CRC-16-CCITT, one 6-bit symbol per visible pixel, MSB first.
    always_comb begin
        sym     = {pix_r, pix_g, pix_b};
        crc_acc = crc_q;
        if (pix_valid) begin
            for (int i = 5; i >= 0; i--) begin
                if (crc_acc[15] ^ sym[i])
                    crc_acc = {crc_acc[14:0], 1'b0} ^ 16'h1021;
                else
                    crc_acc = {crc_acc[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= '0;
        end else if (frame_done_d) begin
            frame_crc_q <= crc_acc;
            crc_q       <= 16'hFFFF;
        end else if (!locked) begin
            crc_q       <= 16'hFFFF;
        end else begin
            crc_q       <= crc_acc;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = '0;
`endif

endmodule
